// File: rtl/adder_chk_pkg.sv
// rtl/adder_chk_pkg.sv - shared FSM encoding and reference sum for adder_checker
// Purpose: state encoding constants and the golden adder model used by the
//          checker's compare stage.
// Ports:   none (package).
package adder_chk_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Widest operand the reference model supports; callers zero-extend their
  // WIDTH-bit operands into it and keep the low WIDTH+1 bits of the result.
  localparam int REF_MAX_W = 32;

  function automatic logic [REF_MAX_W:0] ref_sum(input logic [REF_MAX_W-1:0] a,
                                                 input logic [REF_MAX_W-1:0] b);
    ref_sum = {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/adder_chk_cmp.sv
// rtl/adder_chk_cmp.sv - stage-1 vector capture and stage-2 reference compare
// Purpose: registers each accepted vector together with its reference sum,
//          then compares the observed {carry,out} against it one cycle later.
// Ports:   i_clk, i_rst (sync, active-high)
//          i_load          accepted-vector strobe (transfer)
//          i_in0/i_in1     operands, i_out/i_carry observed adder result
//          o_mismatch_v    1-cycle pulse: captured vector disagrees with ref
//          o_cap_*         the captured vector (valid while it is compared)
module adder_chk_cmp #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_in0,
  input  logic [WIDTH-1:0] i_in1,
  input  logic [WIDTH-1:0] i_out,
  input  logic             i_carry,
  output logic             o_mismatch_v,
  output logic [WIDTH-1:0] o_cap_in0,
  output logic [WIDTH-1:0] o_cap_in1,
  output logic [WIDTH-1:0] o_cap_out,
  output logic             o_cap_carry
);
  import adder_chk_pkg::*;

  logic             r_v;
  logic [WIDTH-1:0] r_in0;
  logic [WIDTH-1:0] r_in1;
  logic [WIDTH-1:0] r_out;
  logic             r_carry;
  logic [WIDTH:0]   r_exp;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_v     <= 1'b0;
      r_in0   <= '0;
      r_in1   <= '0;
      r_out   <= '0;
      r_carry <= 1'b0;
      r_exp   <= '0;
    end else begin
      r_v <= i_load;
      if (i_load) begin
        r_in0   <= i_in0;
        r_in1   <= i_in1;
        r_out   <= i_out;
        r_carry <= i_carry;
        r_exp   <= (WIDTH+1)'(ref_sum(REF_MAX_W'(i_in0), REF_MAX_W'(i_in1)));
      end
    end
  end

  assign o_mismatch_v = r_v && ({r_carry, r_out} != r_exp);
  assign o_cap_in0    = r_in0;
  assign o_cap_in1    = r_in1;
  assign o_cap_out    = r_out;
  assign o_cap_carry  = r_carry;

endmodule

// File: rtl/adder_checker.sv
// rtl/adder_checker.sv - response checker for a WIDTH-bit adder (in0/in1 -> out/carry)
// Purpose: accepts observed adder vectors over valid/ready, compares each to
//          a reference sum, counts vectors and mismatches, captures the first
//          failing vector and reports done/pass after EXP_COUNT vectors.
// Build option: ADDER_CHECKER_HALT_ON_ERR_EN - first mismatch ends the run.
// Ports:   i_clk, i_rst (sync, active-high), i_start (run pulse)
//          i_in_valid/o_in_ready handshake, i_in0/i_in1/i_out/i_carry vector
//          o_busy, o_done, o_pass status; o_vec_cnt, o_err_cnt counters
//          o_fail_valid, o_fail_in0/in1/out/carry first failing vector
module adder_checker #(
  parameter int WIDTH     = 4,
  parameter int CNT_W     = 16,
  parameter int EXP_COUNT = 2**(2*WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_in0,
  input  logic [WIDTH-1:0] i_in1,
  input  logic [WIDTH-1:0] i_out,
  input  logic             i_carry,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic [CNT_W-1:0] o_vec_cnt,
  output logic [CNT_W-1:0] o_err_cnt,
  output logic             o_fail_valid,
  output logic [WIDTH-1:0] o_fail_in0,
  output logic [WIDTH-1:0] o_fail_in1,
  output logic [WIDTH-1:0] o_fail_out,
  output logic             o_fail_carry
);
  import adder_chk_pkg::*;

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(EXP_COUNT - 1);
  localparam logic [CNT_W-1:0] LP_SAT  = '1;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_vec_cnt;
  logic [CNT_W-1:0] r_err_cnt;
  logic             r_fail_valid;
  logic [WIDTH-1:0] r_fail_in0;
  logic [WIDTH-1:0] r_fail_in1;
  logic [WIDTH-1:0] r_fail_out;
  logic             r_fail_carry;

  logic             w_xfer;
  logic             w_mis_raw;
  logic             w_mis;
  logic             w_halt;
  logic [WIDTH-1:0] w_cap_in0;
  logic [WIDTH-1:0] w_cap_in1;
  logic [WIDTH-1:0] w_cap_out;
  logic             w_cap_carry;

  assign o_in_ready = (r_state == ST_RUN);
  assign o_busy     = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign o_done     = (r_state == ST_DONE);
  assign o_pass     = o_done && (r_err_cnt == '0);
  assign w_xfer     = i_in_valid && o_in_ready;

  adder_chk_cmp #(.WIDTH(WIDTH)) u_cmp (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_load       (w_xfer),
    .i_in0        (i_in0),
    .i_in1        (i_in1),
    .i_out        (i_out),
    .i_carry      (i_carry),
    .o_mismatch_v (w_mis_raw),
    .o_cap_in0    (w_cap_in0),
    .o_cap_in1    (w_cap_in1),
    .o_cap_out    (w_cap_out),
    .o_cap_carry  (w_cap_carry)
  );

  // Only compares belonging to the current run count. After a halt, the
  // vector accepted on the halting edge is still compared in DONE; gating on
  // busy keeps it out of the totals.
  assign w_mis = w_mis_raw && o_busy;

`ifdef ADDER_CHECKER_HALT_ON_ERR_EN
  assign w_halt = w_mis;
`else
  assign w_halt = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_vec_cnt    <= '0;
      r_err_cnt    <= '0;
      r_fail_valid <= 1'b0;
      r_fail_in0   <= '0;
      r_fail_in1   <= '0;
      r_fail_out   <= '0;
      r_fail_carry <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (i_start) begin
            r_state      <= ST_RUN;
            r_vec_cnt    <= '0;
            r_err_cnt    <= '0;
            r_fail_valid <= 1'b0;
            r_fail_in0   <= '0;
            r_fail_in1   <= '0;
            r_fail_out   <= '0;
            r_fail_carry <= 1'b0;
          end
        end
        ST_RUN: begin
          if (w_halt) begin
            r_state <= ST_DONE;
          end else if (w_xfer && (r_vec_cnt == LP_LAST)) begin
            r_state <= ST_DRAIN;
          end
        end
        default: r_state <= ST_DONE;
      endcase

      // Transfers and compares only happen while busy, so these never
      // collide with the clears done on start.
      if (w_xfer && !w_halt) begin
        r_vec_cnt <= r_vec_cnt + 1'b1;
      end
      if (w_mis) begin
        if (r_err_cnt != LP_SAT) begin
          r_err_cnt <= r_err_cnt + 1'b1;
        end
        if (!r_fail_valid) begin
          r_fail_valid <= 1'b1;
          r_fail_in0   <= w_cap_in0;
          r_fail_in1   <= w_cap_in1;
          r_fail_out   <= w_cap_out;
          r_fail_carry <= w_cap_carry;
        end
      end
    end
  end

  assign o_vec_cnt    = r_vec_cnt;
  assign o_err_cnt    = r_err_cnt;
  assign o_fail_valid = r_fail_valid;
  assign o_fail_in0   = r_fail_in0;
  assign o_fail_in1   = r_fail_in1;
  assign o_fail_out   = r_fail_out;
  assign o_fail_carry = r_fail_carry;

endmodule
